plru_array_master: RTL

//   Initiator side of the single-port cache metadata array port (csb0/web0/addr0/din0/dout0).

---
 rtl/plru_array_master_if.sv | 40 ++++
 rtl/plru_array_master.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/plru_array_master_if.sv
// Bundle between the cache control side, the PLRU read-modify-write master and the
// metadata array (csb0/web0/addr0/din0/dout0).
//
// Handshake: a request transfers on a rising clk edge where req_valid and req_ready
// are both 1. The requester keeps req_valid, req_op, req_set and req_way stable until
// that edge. rsp_valid is a single-cycle pulse with no back-pressure; rsp_way is
// meaningful only while rsp_valid is 1. Array strobes csb0/web0 are active-low.
`timescale 1ns/1ps
interface plru_array_master_if #(
  parameter int S_INDEX = 4,
  parameter int WAYS    = 4
);
  localparam int LW = $clog2(WAYS);
  localparam int W  = WAYS - 1;

  logic               req_valid;
  logic               req_ready;
  logic               req_op;
  logic [S_INDEX-1:0] req_set;
  logic [LW-1:0]      req_way;
  logic               rsp_valid;
  logic [LW-1:0]      rsp_way;
  logic               csb0;
  logic               web0;
  logic [S_INDEX-1:0] addr0;
  logic [W-1:0]       din0;
  logic [W-1:0]       dout0;

  // The PLRU master: takes requests, returns responses, drives the array port.
  modport master (
    input  req_valid, req_op, req_set, req_way, dout0,
    output req_ready, rsp_valid, rsp_way, csb0, web0, addr0, din0
  );

  // Everything around the master: requester plus array.
  modport slave (
    output req_valid, req_op, req_set, req_way, dout0,
    input  req_ready, rsp_valid, rsp_way, csb0, web0, addr0, din0
  );
endinterface

// File: rtl/plru_array_master.sv
// Tree-PLRU array master. Owns one single-port PLRU metadata array: optionally clears
// it after reset, then services touch (hit update) and victim (replacement query)
// requests by read-modify-write, one request in flight.
//
// Optional feature macro: PLRU_INIT_SWEEP_EN
//   defined     -> reset enters INIT and writes zero to every set before going IDLE.
//   not defined -> reset enters IDLE directly; the array's own reset clears contents.
//
// Tree layout: heap-indexed nodes, root 0, children 2n+1 / 2n+2. A node bit of 0
// points left, 1 points right. dbg_state_o exposes the FSM state.
`timescale 1ns/1ps
module plru_array_master #(
  parameter int S_INDEX = 4,
  parameter int WAYS    = 4,
  parameter int RD_LAT  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  plru_array_master_if.master bus,
  output logic [2:0]         dbg_state_o
);
  localparam int LW = $clog2(WAYS);
  localparam int W  = WAYS - 1;
  localparam int NW = (W > 1) ? $clog2(W) : 1;

  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_WT   = 3'd3;
  localparam logic [2:0] ST_RSP  = 3'd4;

  localparam logic [S_INDEX-1:0] ADDR_LAST = '1;

  logic [2:0]         state_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic [LW-1:0]      rsp_way_q;
  logic               csb0_q;
  logic               web0_q;
  logic [S_INDEX-1:0] addr0_q;
  logic [W-1:0]       din0_q;
  logic               op_q;
  logic [LW-1:0]      way_q;

  logic [W-1:0]       tree_d;
  logic [LW-1:0]      victim_d;

  // Mark every node on way w's path as pointing away from w; other nodes keep their bits.
  function automatic logic [W-1:0] touch_tree(input logic [W-1:0] t, input logic [LW-1:0] w);
    logic [W-1:0]  r;
    logic [LW-1:0] wv;
    logic          b;
    int            node;
    r    = t;
    wv   = w;
    node = 0;
    for (int l = 0; l < LW; l++) begin
      b               = wv[LW-1];
      wv              = wv << 1;
      r[NW'(node)]    = ~b;
      node            = 2 * node + 1 + (b ? 1 : 0);
    end
    return r;
  endfunction

  // Follow the node bits from the root; the bits taken, MSB first, form the victim way.
  function automatic logic [LW-1:0] victim_way(input logic [W-1:0] t);
    logic [LW-1:0] v;
    logic          b;
    int            node;
    v    = '0;
    node = 0;
    for (int l = 0; l < LW; l++) begin
      b    = t[NW'(node)];
      v    = (v << 1) | LW'(b);
      node = 2 * node + 1 + (b ? 1 : 0);
    end
    return v;
  endfunction

  // Updated tree and victim decoded from whatever the array currently returns.
  always_comb begin
    tree_d   = touch_tree(bus.dout0, way_q);
    victim_d = victim_way(bus.dout0);
  end

  // Main FSM: init sweep, accept, read, optional wait, respond/write back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
`ifdef PLRU_INIT_SWEEP_EN
      state_q   <= ST_INIT;
`else
      state_q   <= ST_IDLE;
`endif
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_way_q   <= '0;
      csb0_q      <= 1'b1;
      web0_q      <= 1'b1;
      addr0_q     <= '0;
      din0_q      <= '0;
      op_q        <= 1'b0;
      way_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          req_ready_q <= 1'b0;
          if (csb0_q) begin
            // First sweep cycle: start writing zero at set 0.
            csb0_q  <= 1'b0;
            web0_q  <= 1'b0;
            addr0_q <= '0;
            din0_q  <= '0;
          end else if (addr0_q == ADDR_LAST) begin
            // Last set written; the sweep counter returns to 0 only here.
            csb0_q      <= 1'b1;
            web0_q      <= 1'b1;
            addr0_q     <= '0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            addr0_q <= addr0_q + S_INDEX'(1);
          end
        end

        ST_IDLE: begin
          csb0_q <= 1'b1;
          web0_q <= 1'b1;
          if (req_ready_q && bus.req_valid) begin
            op_q        <= bus.req_op;
            way_q       <= bus.req_way;
            addr0_q     <= bus.req_set;
            csb0_q      <= 1'b0;
            web0_q      <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= ST_RD;
          end else begin
            req_ready_q <= 1'b1;
          end
        end

        ST_RD: begin
          if (RD_LAT == 0) begin
            // Combinational array: read data is valid now, go straight to respond.
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
            if (op_q) begin
              csb0_q    <= 1'b1;
              web0_q    <= 1'b1;
              rsp_way_q <= victim_d;
            end else begin
              csb0_q    <= 1'b0;
              web0_q    <= 1'b0;
              din0_q    <= tree_d;
              rsp_way_q <= way_q;
            end
          end else begin
            // Registered array: deselect and pick the data up one cycle later.
            csb0_q  <= 1'b1;
            web0_q  <= 1'b1;
            state_q <= ST_WT;
          end
        end

        ST_WT: begin
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RSP;
          if (op_q) begin
            csb0_q    <= 1'b1;
            web0_q    <= 1'b1;
            rsp_way_q <= victim_d;
          end else begin
            csb0_q    <= 1'b0;
            web0_q    <= 1'b0;
            din0_q    <= tree_d;
            rsp_way_q <= way_q;
          end
        end

        ST_RSP: begin
          // Write-back (touch) completes on this edge; array is released for IDLE.
          csb0_q      <= 1'b1;
          web0_q      <= 1'b1;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end

        default: begin
          csb0_q      <= 1'b1;
          web0_q      <= 1'b1;
          req_ready_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_way   = rsp_way_q;
  assign bus.csb0      = csb0_q;
  assign bus.web0      = web0_q;
  assign bus.addr0     = addr0_q;
  assign bus.din0      = din0_q;
  assign dbg_state_o   = state_q;
endmodule
